onehot_grant_decoder: RTL and testbench

//   Sequential 3-to-8 decoder. It is the counterpart of priority_encoder_8to3: it takes encoded

---
 rtl/onehot_grant_decoder.sv | 157 +++++++++++++++
 tb/tb_onehot_grant_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_grant_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_grant_decoder
// Brief    : Buffers encoded indices in a small FIFO and issues them one at a
//            time as a registered one-hot grant, held until done is pulsed.
//            Optional all-zero gap between consecutive grants.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_grant_decoder #(
  parameter int N_OUT = 8,
  parameter int IDX_W = 3,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_idx,
  output logic                     in_ready,
  output logic [N_OUT-1:0]         grant,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_idx
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GCNT_W-1:0] GAP_LOAD  = (GAP > 0) ? GCNT_W'(GAP - 1) : '0;
  localparam logic [IDX_W:0]    N_OUT_LIM = (IDX_W + 1)'(N_OUT);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  state_t              state;
  logic [GCNT_W-1:0]   gap_cnt;
  logic [IDX_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic                push;
  logic                bad_idx;
  logic                store;
  logic                pop;
  logic                has_entry;
  logic [IDX_W-1:0]    head;

  // Decode an index into a one-hot vector; out-of-range indices never reach here.
  function automatic logic [N_OUT-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  // Readiness depends only on occupancy, so a same-cycle pop never frees a slot.
  assign in_ready  = (count < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign bad_idx   = ({1'b0, in_idx} >= N_OUT_LIM);
  assign store     = push && !bad_idx;
  assign has_entry = (count != '0);
  assign head      = mem[rd_ptr];
  // Pops happen when IDLE loads a grant, or when a back-to-back reload occurs (GAP==0).
  assign pop       = ((state == IDLE) && has_entry) ||
                     ((state == GRANT) && done && (GAP == 0) && has_entry);

  // FIFO storage; data needs no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= in_idx;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Grant sequencer with registered grant, grant_valid, grant_idx and err_idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      gap_cnt     <= '0;
      err_idx     <= 1'b0;
    end else begin
      err_idx <= push && bad_idx;
      case (state)
        IDLE: begin
          if (has_entry) begin
            grant       <= decode(head);
            grant_idx   <= head;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (done) begin
            if (GAP > 0) begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              gap_cnt     <= GAP_LOAD;
              state       <= GAPW;
            end else if (has_entry) begin
              grant       <= decode(head);
              grant_idx   <= head;
              grant_valid <= 1'b1;
            end else begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        GAPW: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GCNT_W'(1);
          end
        end
        default: begin
          grant       <= '0;
          grant_idx   <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_grant_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_grant_decoder
// Brief    : Table-driven and directed checks for onehot_grant_decoder, using a
//            default instance (GAP=1) and a GAP=0 / N_OUT=6 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_grant_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: N_OUT=8, GAP=1
  logic       rst_n = 1'b0, in_valid = 1'b0, done = 1'b0;
  logic [2:0] in_idx = '0;
  logic       in_ready, grant_valid, err_idx;
  logic [7:0] grant;
  logic [2:0] grant_idx, count;

  // Second instance: N_OUT=6 so bad indices exist, GAP=0 for back-to-back reload
  logic       b_rst_n = 1'b0, b_in_valid = 1'b0, b_done = 1'b0;
  logic [2:0] b_in_idx = '0;
  logic       b_in_ready, b_grant_valid, b_err_idx;
  logic [5:0] b_grant;
  logic [2:0] b_grant_idx, b_count;

  onehot_grant_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx),
    .in_ready(in_ready), .grant(grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .done(done), .count(count), .err_idx(err_idx)
  );

  onehot_grant_decoder #(.N_OUT(6), .IDX_W(3), .DEPTH(4), .GAP(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_idx(b_in_idx),
    .in_ready(b_in_ready), .grant(b_grant), .grant_valid(b_grant_valid),
    .grant_idx(b_grant_idx), .done(b_done), .count(b_count), .err_idx(b_err_idx)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] idx, input logic d);
    @(negedge clk);
    rst_n = r; in_valid = v; in_idx = idx; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic r, input logic v, input logic [2:0] idx, input logic d);
    @(negedge clk);
    b_rst_n = r; b_in_valid = v; b_in_idx = idx; b_done = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [2:0] idx;
    logic       dn;
    logic [7:0] g;
    logic       gv;
    logic [2:0] gi;
    logic [2:0] cnt;
    logic       rdy;
    logic       err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset, single grant held 10 cycles, GAP+1 zero cycles before next grant
    vecs[0] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0};
    for (int k = 3; k <= 12; k++)
      vecs[k] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 3'd2, 1'b1, 8'h00, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].rst_n, vecs[k].vld, vecs[k].idx, vecs[k].dn);
      chk($sformatf("v%0d grant", k),       32'(grant),       32'(vecs[k].g));
      chk($sformatf("v%0d grant_valid", k), 32'(grant_valid), 32'(vecs[k].gv));
      chk($sformatf("v%0d grant_idx", k),   32'(grant_idx),   32'(vecs[k].gi));
      chk($sformatf("v%0d count", k),       32'(count),       32'(vecs[k].cnt));
      chk($sformatf("v%0d in_ready", k),    32'(in_ready),    32'(vecs[k].rdy));
      chk($sformatf("v%0d err_idx", k),     32'(err_idx),     32'(vecs[k].err));
    end
    drive(1'b1, 1'b0, 3'd0, 1'b0);

    // Sweep: push 0..7 while a consumer pulses done one cycle after each grant
    fork
      begin
        int  k;
        int  tries;
        logic rdy;
        k = 0;
        tries = 0;
        while (k < 8 && tries < 300) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_idx   = 3'(k);
          rdy      = in_ready;
          @(posedge clk);
          if (rdy) k++;
          tries++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (k < 8) chk("sweep push timeout", 32'(k), 32'd8);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          int w;
          logic [7:0] exp_g;
          w = 0;
          exp_g = 8'h01 << i;
          @(negedge clk);
          while (!grant_valid && w < 40) begin
            chk("sweep idle zero", 32'(grant), 32'd0);
            @(negedge clk);
            w++;
          end
          if (!grant_valid) begin
            chk($sformatf("sweep grant %0d timeout", i), 32'(grant_valid), 32'd1);
          end else begin
            chk($sformatf("sweep grant %0d", i), 32'(grant), 32'(exp_g));
            chk($sformatf("sweep grant_idx %0d", i), 32'(grant_idx), 32'(i));
          end
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
        end
      end
    join
    repeat (3) drive(1'b1, 1'b0, 3'd0, 1'b0);
    chk("sweep end count", 32'(count), 32'd0);
    chk("sweep end grant", 32'(grant), 32'd0);

    // Full: 5 accepted (1 granted + 4 queued), the 6th waits for a free slot
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b1, 3'd1, 1'b0);
    drive(1'b1, 1'b1, 3'd2, 1'b0);
    drive(1'b1, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 3'd4, 1'b0);
    drive(1'b1, 1'b1, 3'd5, 1'b0);
    drive(1'b1, 1'b1, 3'd6, 1'b0);
    chk("full count", 32'(count), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full grant", 32'(grant), 32'h02);
    drive(1'b1, 1'b1, 3'd6, 1'b1);
    chk("full done grant", 32'(grant), 32'h00);
    chk("full done count", 32'(count), 32'd4);
    drive(1'b1, 1'b1, 3'd6, 1'b0);
    chk("full gap count", 32'(count), 32'd4);
    drive(1'b1, 1'b1, 3'd6, 1'b0);
    chk("full pop grant", 32'(grant), 32'h04);
    chk("full pop count", 32'(count), 32'd3);
    chk("full pop in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 3'd6, 1'b0);
    chk("full held push count", 32'(count), 32'd4);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      int w;
      w = 0;
      drive(1'b1, 1'b0, 3'd0, 1'b1);
      while (!grant_valid && w < 10) begin
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        w++;
      end
      chk($sformatf("full drain idx %0d", i), 32'(grant_idx), 32'(i));
    end

    // Reset mid-operation: grant 8'h08 active with 3 queued
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 3'd1, 1'b0);
    drive(1'b1, 1'b1, 3'd2, 1'b0);
    drive(1'b1, 1'b1, 3'd4, 1'b0);
    chk("midrst pre grant", 32'(grant), 32'h08);
    chk("midrst pre count", 32'(count), 32'd3);
    drive(1'b0, 1'b1, 3'd5, 1'b1);
    chk("midrst grant", 32'(grant), 32'h00);
    chk("midrst grant_valid", 32'(grant_valid), 32'd0);
    chk("midrst count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b0);
      chk($sformatf("midrst after %0d grant", i), 32'(grant), 32'h00);
      chk($sformatf("midrst after %0d count", i), 32'(count), 32'd0);
    end

    // GAP=0 instance: simultaneous push and pop, bad indices, back-to-back grants
    drive_b(1'b0, 1'b0, 3'd0, 1'b0);
    drive_b(1'b0, 1'b0, 3'd0, 1'b0);
    chk("b reset count", 32'(b_count), 32'd0);
    chk("b reset in_ready", 32'(b_in_ready), 32'd1);
    drive_b(1'b1, 1'b1, 3'd1, 1'b0);
    drive_b(1'b1, 1'b1, 3'd2, 1'b0);
    drive_b(1'b1, 1'b1, 3'd3, 1'b0);
    chk("b pre grant", 32'(b_grant), 32'h02);
    chk("b pre count", 32'(b_count), 32'd2);
    drive_b(1'b1, 1'b1, 3'd4, 1'b1);
    chk("b simul grant", 32'(b_grant), 32'h04);
    chk("b simul grant_idx", 32'(b_grant_idx), 32'd2);
    chk("b simul count", 32'(b_count), 32'd2);
    drive_b(1'b1, 1'b1, 3'd7, 1'b0);
    chk("b bad7 err", 32'(b_err_idx), 32'd1);
    chk("b bad7 count", 32'(b_count), 32'd2);
    drive_b(1'b1, 1'b1, 3'd6, 1'b0);
    chk("b bad6 err", 32'(b_err_idx), 32'd1);
    chk("b bad6 count", 32'(b_count), 32'd2);
    drive_b(1'b1, 1'b0, 3'd0, 1'b0);
    chk("b err clear", 32'(b_err_idx), 32'd0);
    drive_b(1'b1, 1'b0, 3'd0, 1'b1);
    chk("b b2b grant3", 32'(b_grant), 32'h08);
    chk("b b2b count1", 32'(b_count), 32'd1);
    drive_b(1'b1, 1'b0, 3'd0, 1'b1);
    chk("b b2b grant4", 32'(b_grant), 32'h10);
    chk("b b2b count0", 32'(b_count), 32'd0);
    drive_b(1'b1, 1'b0, 3'd0, 1'b1);
    chk("b empty grant", 32'(b_grant), 32'h00);
    chk("b empty grant_valid", 32'(b_grant_valid), 32'd0);
    chk("b empty grant_idx", 32'(b_grant_idx), 32'd0);
    drive_b(1'b1, 1'b1, 3'd5, 1'b0);
    chk("b idx5 err", 32'(b_err_idx), 32'd0);
    chk("b idx5 count", 32'(b_count), 32'd1);
    drive_b(1'b1, 1'b0, 3'd0, 1'b0);
    chk("b idx5 grant", 32'(b_grant), 32'h20);
    chk("b idx5 grant_idx", 32'(b_grant_idx), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
